pong_game_ctrl: RTL and testbench

Game-sequencing controller for the pong datapath. It gates ball motion, schedules serves, keeps both scores and detects game over, all driven by frame ticks from the VGA vblank. It sits between the collision detector, which supplies the coll_wall and coll_paddle pulses, and the ball and paddle blocks, which take run, serve and speed controls. All logic runs in the pixel-clock domain.

---
 rtl/pong_game_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for the pong datapath.
// It gates ball motion, schedules serves, keeps both scores and detects
// game over. All timing is in frames, counted from vblank rising edges.
// The optional rally speed-up is enabled by defining PONG_SPEEDUP_EN.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int RALLY_STEP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblank,
  input  logic       start,
  input  logic       coll_paddle,
  input  logic       coll_wall,
  input  logic       wall_side,
  input  logic [3:0] speed_in,
  output logic       ball_run,
  output logic       ball_serve,
  output logic       serve_dir,
  output logic [3:0] speed,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  // The frame counter only has to hold the larger of the two delays.
  localparam int CntMax = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ServeLoad = CntW'(SERVE_FRAMES);
  localparam logic [CntW-1:0] PointLoad = CntW'(POINT_FRAMES);
  localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);

  logic            startMeta_q;
  logic            startSync_q;
  logic            startPrev_q;
  logic            startRise;
  logic            vblank_q;
  logic            tick;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      scoreLeft_q, scoreLeft_d;
  logic [3:0]      scoreRight_q, scoreRight_d;
  logic            serveDir_q, serveDir_d;
  logic            winner_q, winner_d;
  logic            ballServe_q, ballServe_d;

  logic            wallHit;
  logic            paddleHit;
  logic [3:0]      scoreLeftInc;
  logic [3:0]      scoreRightInc;

  // Bring the asynchronous start button into the clock domain and find its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startMeta_q <= 1'b0;
      startSync_q <= 1'b0;
      startPrev_q <= 1'b0;
    end else begin
      startMeta_q <= start;
      startSync_q <= startMeta_q;
      startPrev_q <= startSync_q;
    end
  end

  assign startRise = startSync_q & ~startPrev_q;

  // Delay vblank by one cycle so that its rising edge becomes a one-cycle frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= vblank;
    end
  end

  assign tick = vblank & ~vblank_q;

  // Collisions only count while the ball is live; a wall hit masks a simultaneous paddle hit.
  assign wallHit       = (state_q == ST_PLAY) & coll_wall;
  assign paddleHit     = (state_q == ST_PLAY) & coll_paddle & ~coll_wall;
  assign scoreLeftInc  = scoreLeft_q + 4'd1;
  assign scoreRightInc = scoreRight_q + 4'd1;

  // Next-state logic: game flow, frame countdowns, scoring and serve direction.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scoreLeft_d  = scoreLeft_q;
    scoreRight_d = scoreRight_q;
    serveDir_d   = serveDir_q;
    winner_d     = winner_q;
    ballServe_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (startRise) begin
          scoreLeft_d  = 4'd0;
          scoreRight_d = 4'd0;
          serveDir_d   = 1'b1;
          winner_d     = 1'b0;
          cnt_d        = ServeLoad;
          state_d      = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == '0) begin
            state_d     = ST_PLAY;
            ballServe_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end

      ST_PLAY: begin
        if (wallHit) begin
          serveDir_d = wall_side;
          if (!wall_side) begin
            scoreRight_d = scoreRightInc;
            if (scoreRightInc == WinScore) begin
              winner_d = 1'b1;
              state_d  = ST_OVER;
            end else begin
              cnt_d   = PointLoad;
              state_d = ST_POINT;
            end
          end else begin
            scoreLeft_d = scoreLeftInc;
            if (scoreLeftInc == WinScore) begin
              winner_d = 1'b0;
              state_d  = ST_OVER;
            end else begin
              cnt_d   = PointLoad;
              state_d = ST_POINT;
            end
          end
        end
      end

      ST_POINT: begin
        if (tick) begin
          if (cnt_q == '0) begin
            cnt_d   = ServeLoad;
            state_d = ST_SERVE;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Game state registers; reset returns to IDLE with a rightward serve pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      scoreLeft_q  <= 4'd0;
      scoreRight_q <= 4'd0;
      serveDir_q   <= 1'b1;
      winner_q     <= 1'b0;
      ballServe_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scoreLeft_q  <= scoreLeft_d;
      scoreRight_q <= scoreRight_d;
      serveDir_q   <= serveDir_d;
      winner_q     <= winner_d;
      ballServe_q  <= ballServe_d;
    end
  end

`ifdef PONG_SPEEDUP_EN
  localparam int RallyW = (RALLY_STEP < 2) ? 1 : $clog2(RALLY_STEP);
  localparam logic [RallyW-1:0] RallyLast = RallyW'(RALLY_STEP - 1);

  logic [RallyW-1:0] rally_q;
  logic [3:0]        boost_q;
  logic [4:0]        speedSum;
  logic              enterServe;

  assign enterServe = (state_d == ST_SERVE) && (state_q != ST_SERVE);
  assign speedSum   = {1'b0, speed_in} + {1'b0, boost_q};

  // Count accepted paddle hits and raise the boost every RALLY_STEP hits until speed tops out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rally_q <= '0;
      boost_q <= 4'd0;
    end else if (enterServe) begin
      rally_q <= '0;
      boost_q <= 4'd0;
    end else if (paddleHit) begin
      if (rally_q == RallyLast) begin
        rally_q <= '0;
        if (speedSum < 5'd15) begin
          boost_q <= boost_q + 4'd1;
        end
      end else begin
        rally_q <= rally_q + RallyW'(1);
      end
    end
  end

  assign speed = (speedSum > 5'd15) ? 4'd15 : speedSum[3:0];
`else
  // Without the speed-up, paddle hits and the rally step have no consumer.
  localparam int unusedRallyStep = RALLY_STEP;
  logic unusedPaddleHit;
  assign unusedPaddleHit = paddleHit;
  assign speed           = speed_in;
`endif

  assign ball_run    = (state_q == ST_PLAY);
  assign ball_serve  = ballServe_q;
  assign serve_dir   = serveDir_q;
  assign score_left  = scoreLeft_q;
  assign score_right = scoreRight_q;
  assign game_over   = (state_q == ST_OVER);
  assign winner      = winner_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl with short frame delays and a
// four-point game. Speed expectations follow PONG_SPEEDUP_EN.
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       vblank;
  logic       start;
  logic       coll_paddle;
  logic       coll_wall;
  logic       wall_side;
  logic [3:0] speed_in;
  logic       ball_run;
  logic       ball_serve;
  logic       serve_dir;
  logic [3:0] speed;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  int compared;
  int mismatched;

  pong_game_ctrl #(
    .WIN_SCORE   (4),
    .SERVE_FRAMES(2),
    .POINT_FRAMES(1),
    .RALLY_STEP  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblank     (vblank),
    .start      (start),
    .coll_paddle(coll_paddle),
    .coll_wall  (coll_wall),
    .wall_side  (wall_side),
    .speed_in   (speed_in),
    .ball_run   (ball_run),
    .ball_serve (ball_serve),
    .serve_dir  (serve_dir),
    .speed      (speed),
    .score_left (score_left),
    .score_right(score_right),
    .game_over  (game_over),
    .winner     (winner),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // One frame tick: vblank low for a cycle, then high across one active edge.
  task automatic applyStimulus();
    vblank = 1'b0;
    stepClk();
    vblank = 1'b1;
    stepClk();
    vblank = 1'b0;
  endtask

  task automatic pressStart();
    start = 1'b1;
    repeat (4) stepClk();
    start = 1'b0;
    repeat (3) stepClk();
  endtask

  task automatic hit(input logic wall, input logic side, input logic paddle);
    coll_wall   = wall;
    wall_side   = side;
    coll_paddle = paddle;
    stepClk();
    coll_wall   = 1'b0;
    coll_paddle = 1'b0;
  endtask

  // POINT takes two ticks, SERVE three, landing in the first PLAY cycle.
  task automatic pointToPlay();
    repeat (5) applyStimulus();
  endtask

  initial begin
    logic [3:0] expSpeed;
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b0;
    vblank      = 1'b0;
    start       = 1'b0;
    coll_paddle = 1'b0;
    coll_wall   = 1'b0;
    wall_side   = 1'b0;
    speed_in    = 4'd13;

    repeat (2) stepClk();
    checkOutput("reset_state", 8'(state), 8'd0);
    checkOutput("reset_ball_run", 8'(ball_run), 8'd0);
    checkOutput("reset_ball_serve", 8'(ball_serve), 8'd0);
    checkOutput("reset_serve_dir", 8'(serve_dir), 8'd1);
    checkOutput("reset_scores", 8'({score_left, score_right}), 8'd0);
    checkOutput("reset_game_over", 8'(game_over), 8'd0);
    checkOutput("reset_winner", 8'(winner), 8'd0);
    checkOutput("reset_speed", 8'(speed), 8'd13);
    rst_n = 1'b1;
    stepClk();

    pressStart();
    checkOutput("start_state", 8'(state), 8'd1);
    checkOutput("start_serve_dir", 8'(serve_dir), 8'd1);
    checkOutput("serve_ball_run", 8'(ball_run), 8'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("serve_after2_state", 8'(state), 8'd1);
    applyStimulus();
    checkOutput("play_state", 8'(state), 8'd2);
    checkOutput("play_ball_run", 8'(ball_run), 8'd1);
    checkOutput("play_ball_serve", 8'(ball_serve), 8'd1);
    stepClk();
    checkOutput("ball_serve_one_cycle", 8'(ball_serve), 8'd0);

    hit(1'b1, 1'b0, 1'b0);
    checkOutput("left_wall_score_right", 8'(score_right), 8'd1);
    checkOutput("left_wall_state", 8'(state), 8'd3);
    checkOutput("left_wall_serve_dir", 8'(serve_dir), 8'd0);
    applyStimulus();
    checkOutput("point_tick1_state", 8'(state), 8'd3);
    applyStimulus();
    checkOutput("point_expire_state", 8'(state), 8'd1);

    hit(1'b1, 1'b1, 1'b0);
    checkOutput("serve_wall_ignored", 8'({score_left, score_right}), 8'h01);
    checkOutput("serve_wall_state", 8'(state), 8'd1);
    repeat (3) applyStimulus();
    checkOutput("second_play_state", 8'(state), 8'd2);

    hit(1'b1, 1'b1, 1'b1);
    checkOutput("wall_paddle_scores", 8'({score_left, score_right}), 8'h11);
    checkOutput("wall_paddle_state", 8'(state), 8'd3);
    checkOutput("wall_paddle_serve_dir", 8'(serve_dir), 8'd1);
    pointToPlay();
    hit(1'b1, 1'b1, 1'b0);
    pointToPlay();
    hit(1'b1, 1'b1, 1'b0);
    checkOutput("left_three", 8'(score_left), 8'd3);
    applyStimulus();
    checkOutput("mid_point_state", 8'(state), 8'd3);

    rst_n = 1'b0;
    #2;
    checkOutput("async_rst_state", 8'(state), 8'd0);
    checkOutput("async_rst_scores", 8'({score_left, score_right}), 8'd0);
    checkOutput("async_rst_serve_dir", 8'(serve_dir), 8'd1);
    checkOutput("async_rst_ball_run", 8'(ball_run), 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput("post_rst_ball_serve", 8'(ball_serve), 8'd0);
      checkOutput("post_rst_state", 8'(state), 8'd0);
    end

    pressStart();
    repeat (3) applyStimulus();
    for (int i = 1; i <= 4; i++) begin
      hit(1'b1, 1'b0, 1'b0);
      checkOutput("game2_score_right", 8'(score_right), 8'(i));
      if (i < 4) begin
        checkOutput("game2_point_state", 8'(state), 8'd3);
        pointToPlay();
      end
    end
    checkOutput("over_state", 8'(state), 8'd4);
    checkOutput("over_game_over", 8'(game_over), 8'd1);
    checkOutput("over_winner", 8'(winner), 8'd1);
    checkOutput("over_ball_run", 8'(ball_run), 8'd0);
    hit(1'b1, 1'b1, 1'b0);
    checkOutput("over_wall_ignored", 8'({score_left, score_right}), 8'h04);
    checkOutput("over_wall_state", 8'(state), 8'd4);
    pressStart();
    checkOutput("restart_state", 8'(state), 8'd1);
    checkOutput("restart_scores", 8'({score_left, score_right}), 8'd0);
    checkOutput("restart_game_over", 8'(game_over), 8'd0);
    checkOutput("restart_serve_dir", 8'(serve_dir), 8'd1);

    repeat (3) applyStimulus();
    checkOutput("game3_ball_serve", 8'(ball_serve), 8'd1);
    for (int h = 1; h <= 6; h++) begin
      hit(1'b0, 1'b0, 1'b1);
`ifdef PONG_SPEEDUP_EN
      expSpeed = (h >= 4) ? 4'd15 : ((h >= 2) ? 4'd14 : 4'd13);
`else
      expSpeed = 4'd13;
`endif
      checkOutput("rally_speed", 8'(speed), 8'(expSpeed));
    end
    checkOutput("paddle_no_score", 8'({score_left, score_right}), 8'd0);
    hit(1'b1, 1'b1, 1'b0);
    applyStimulus();
    applyStimulus();
    checkOutput("game3_serve_state", 8'(state), 8'd1);
    checkOutput("serve_speed_cleared", 8'(speed), 8'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
